// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Address split is {tag[7:5], index[4:2], offset[1:0]} with one 32-bit block per line.
package dcache_pkg;

   localparam int TAG_W     = 3;
   localparam int IDX_W     = 3;
   localparam int OFF_W     = 2;
   localparam int BLOCK_W   = 32;
   localparam int NUM_LINES = 1 << IDX_W;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for dcache_ctrl: valid/dirty bits (async cleared) plus tag and data (never reset).
// One combinational read port and one byte-enabled write port, both addressed by the same index.
module dcache_line_array
   import dcache_pkg::*;
#(
   parameter int LINES = NUM_LINES
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [IDX_W-1:0]   i_index,
   input  logic               i_we,
   input  logic [3:0]         i_byteEn,
   input  logic [BLOCK_W-1:0] i_wdata,
   input  logic [TAG_W-1:0]   i_tag,
   input  logic               i_dirty,
   output logic               o_valid,
   output logic               o_dirty,
   output logic [TAG_W-1:0]   o_tag,
   output logic [BLOCK_W-1:0] o_data
);

   logic [LINES-1:0]   r_valid;
   logic [LINES-1:0]   r_dirty;
   logic [TAG_W-1:0]   r_tag  [LINES];
   logic [BLOCK_W-1:0] r_data [LINES];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_we) begin
         r_valid[i_index] <= 1'b1;
         r_dirty[i_index] <= i_dirty;
      end
   end

   // Tag and data carry no reset; a line is only trusted once its valid bit is set.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_tag[i_index] <= i_tag;
         for (int b = 0; b < 4; b++) begin
            if (i_byteEn[b]) begin
               r_data[i_index][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_valid = r_valid[i_index];
   assign o_dirty = r_dirty[i_index];
   assign o_tag   = r_tag[i_index];
   assign o_data  = r_data[i_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller: single-cycle hits, write-back/allocate on misses.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES        = 8,
   parameter int MISS_TIMEOUT = 0
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               read,
   input  logic               write,
   input  logic [7:0]         address,
   input  logic [7:0]         writedata,
   output logic [7:0]         readdata,
   output logic               busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [5:0]         mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]        hit_count,
   output logic [15:0]        miss_count
`endif
);

   generate
      if (LINES != NUM_LINES || MISS_TIMEOUT != 0) begin : g_paramCheck
         $error("dcache_ctrl: LINES must be 8 and MISS_TIMEOUT must be 0");
      end
   endgenerate

   state_t             r_state;
   logic               r_mem_read;
   logic               r_mem_write;
   logic [5:0]         r_mem_address;
   logic [BLOCK_W-1:0] r_mem_writedata;

   logic [TAG_W-1:0]   w_tag;
   logic [IDX_W-1:0]   w_index;
   logic [OFF_W-1:0]   w_offset;
   logic               w_req;
   logic               w_hit;
   logic               w_idleHit;
   logic               w_idleMiss;
   logic               w_lineValid;
   logic               w_lineDirty;
   logic [TAG_W-1:0]   w_lineTag;
   logic [BLOCK_W-1:0] w_lineData;
   logic               w_fill;
   logic               w_hitWrite;
   logic               w_we;
   logic [3:0]         w_byteEn;
   logic [BLOCK_W-1:0] w_wdata;

   assign w_tag      = address[7:5];
   assign w_index    = address[4:2];
   assign w_offset   = address[1:0];
   assign w_req      = read ^ write;
   assign w_hit      = w_lineValid && (w_lineTag == w_tag);
   assign w_idleHit  = (r_state == IDLE) && w_req && w_hit;
   assign w_idleMiss = (r_state == IDLE) && w_req && !w_hit;

   // A fill replaces the whole block clean; a hit store merges one byte and marks the line dirty.
   assign w_fill     = (r_state == ALLOCATE) && !mem_busywait;
   assign w_hitWrite = w_idleHit && write;
   assign w_we       = w_fill || w_hitWrite;
   assign w_byteEn   = w_fill ? 4'hF : (4'b0001 << w_offset);
   assign w_wdata    = w_fill ? mem_readdata : {4{writedata}};

   dcache_line_array #(
      .LINES (LINES)
   ) u_lines (
      .i_clk    (clock),
      .i_rst_n  (reset),
      .i_index  (w_index),
      .i_we     (w_we),
      .i_byteEn (w_byteEn),
      .i_wdata  (w_wdata),
      .i_tag    (w_tag),
      .i_dirty  (!w_fill),
      .o_valid  (w_lineValid),
      .o_dirty  (w_lineDirty),
      .o_tag    (w_lineTag),
      .o_data   (w_lineData)
   );

   // Memory-side outputs are registered alongside the state so they change only with it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state         <= IDLE;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_address   <= '0;
         r_mem_writedata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_idleMiss) begin
                  if (w_lineValid && w_lineDirty) begin
                     r_state         <= WRITEBACK;
                     r_mem_write     <= 1'b1;
                     r_mem_address   <= {w_lineTag, w_index};
                     r_mem_writedata <= w_lineData;
                  end else begin
                     r_state       <= ALLOCATE;
                     r_mem_read    <= 1'b1;
                     r_mem_address <= address[7:2];
                  end
               end
            end
            WRITEBACK: begin
               if (!mem_busywait) begin
                  r_state         <= ALLOCATE;
                  r_mem_write     <= 1'b0;
                  r_mem_read      <= 1'b1;
                  r_mem_address   <= address[7:2];
                  r_mem_writedata <= '0;
               end
            end
            ALLOCATE: begin
               if (!mem_busywait) begin
                  r_state       <= IDLE;
                  r_mem_read    <= 1'b0;
                  r_mem_address <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_read      = r_mem_read;
   assign mem_write     = r_mem_write;
   assign mem_address   = r_mem_address;
   assign mem_writedata = r_mem_writedata;

   // Gated with reset so the CPU sees a quiet port while reset is held.
   assign busywait = reset && ((r_state != IDLE) || (w_req && !w_hit));
   assign readdata = (reset && w_idleHit && read) ? w_lineData[{w_offset, 3'b000} +: 8] : 8'h00;

`ifdef DCACHE_STATS_EN
   logic        r_missDone;
   logic [15:0] r_hitCount;
   logic [15:0] r_missCount;

   // The hit cycle that finishes a refill belongs to that miss, so it is not counted as a hit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_missDone  <= 1'b0;
         r_hitCount  <= '0;
         r_missCount <= '0;
      end else begin
         if (w_fill) begin
            r_missDone <= 1'b1;
         end else if (r_state == IDLE) begin
            r_missDone <= 1'b0;
         end
         if (w_idleHit && !r_missDone && (r_hitCount != 16'hFFFF)) begin
            r_hitCount <= r_hitCount + 16'd1;
         end
         if (w_idleMiss && (r_missCount != 16'hFFFF)) begin
            r_missCount <= r_missCount + 16'd1;
         end
      end
   end

   assign hit_count  = r_hitCount;
   assign miss_count = r_missCount;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency memory model and queue-based scoreboards
// for CPU load data and memory transfers. Define DCACHE_STATS_EN to also cover the counters.
module tb_dcache_ctrl;

   localparam int LAT        = 3;
   localparam int CLEAN_MISS = 1 + (LAT + 1);
   localparam int DIRTY_MISS = 1 + 2 * (LAT + 1);

   typedef struct packed {
      logic        isWrite;
      logic [5:0]  addr;
      logic [31:0] data;
   } memOp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [7:0]  address = 8'h00;
   logic [7:0]  writedata = 8'h00;
   logic [7:0]  readdata;
   logic        busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;
`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   logic [31:0] memArr [64];
   logic        memInit = 1'b0;
   int          memCnt = 0;
   memOp_t      memExp[$];
   logic [7:0]  rdExp[$];
   int          passCount = 0;
   int          checkCount = 0;

   dcache_ctrl dut (
      .clock         (clock),
      .reset         (reset),
      .read          (read),
      .write         (write),
      .address       (address),
      .writedata     (writedata),
      .readdata      (readdata),
      .busywait      (busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count     (hit_count),
      .miss_count    (miss_count)
`endif
   );

   always #5 clock = ~clock;

   // Memory raises busywait as soon as a request appears and releases it after LAT edges.
   assign mem_busywait = (mem_read || mem_write) && (memCnt != LAT);
   assign mem_readdata = memArr[mem_address];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   always @(posedge clock) begin
      if (!memInit) begin
         for (int i = 0; i < 64; i++) memArr[i] = 32'h01010101 * i;
         memArr[1] = 32'hDDCCBBAA;
         memArr[9] = 32'h11223344;
         memInit   = 1'b1;
      end
      if ((mem_read || mem_write) && !mem_busywait) begin
         if (mem_write) memArr[mem_address] = mem_writedata;
         memCnt <= 0;
      end else if (mem_read || mem_write) begin
         memCnt <= memCnt + 1;
      end else begin
         memCnt <= 0;
      end
   end

   // A transfer completes at the posedge following a negedge where the memory is not busy.
   always @(negedge clock) begin
      memOp_t e;
      if (reset && (mem_read || mem_write) && !mem_busywait) begin
         checkOutput("memExclusive", 32'(mem_read & mem_write), 32'd0);
         checkOutput("memQueued", 32'(memExp.size() > 0), 32'd1);
         if (memExp.size() > 0) begin
            e = memExp.pop_front();
            checkOutput("memKind", 32'(mem_write), 32'(e.isWrite));
            checkOutput("memAddr", 32'(mem_address), 32'(e.addr));
            if (e.isWrite) checkOutput("memWdata", mem_writedata, e.data);
         end
      end
   end

   task automatic applyStimulus(input string tag, input logic doRd, input logic doWr,
                                input logic [7:0] addr, input logic [7:0] wdata,
                                input logic [7:0] expRd, input int expStall);
      int stalls;
      logic [7:0] e;
      @(negedge clock);
      read      = doRd;
      write     = doWr;
      address   = addr;
      writedata = wdata;
      if (doRd) rdExp.push_back(expRd);
      #1;
      stalls = 0;
      while (busywait && stalls < 200) begin
         @(negedge clock);
         #1;
         stalls++;
      end
      checkOutput({tag, "_stall"}, 32'(stalls), 32'(expStall));
      if (doRd) begin
         e = rdExp.pop_front();
         checkOutput({tag, "_rdata"}, 32'(readdata), 32'(e));
      end
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset with a request already present: every CPU and memory output must read zero.
      read    = 1'b1;
      address = 8'h05;
      repeat (2) @(negedge clock);
      #1;
      checkOutput("rst_busywait", 32'(busywait), 32'd0);
      checkOutput("rst_memRead", 32'(mem_read), 32'd0);
      checkOutput("rst_memWrite", 32'(mem_write), 32'd0);
      checkOutput("rst_memAddr", 32'(mem_address), 32'd0);
      checkOutput("rst_memWdata", mem_writedata, 32'd0);
      checkOutput("rst_readdata", 32'(readdata), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      read  = 1'b0;

      // Clean read miss, then the same byte hits in one cycle.
      memExp.push_back('{1'b0, 6'h01, 32'h0});
      applyStimulus("missRead05", 1'b1, 1'b0, 8'h05, 8'h00, 8'hBB, CLEAN_MISS);
`ifdef DCACHE_STATS_EN
      checkOutput("missCount1", 32'(miss_count), 32'd1);
      checkOutput("hitCount0", 32'(hit_count), 32'd0);
`endif
      applyStimulus("hitRead05", 1'b1, 1'b0, 8'h05, 8'h00, 8'hBB, 0);
      checkOutput("hitNoMemRead", 32'(mem_read), 32'd0);
      @(negedge clock);
      read = 1'b0;
      #1;
`ifdef DCACHE_STATS_EN
      checkOutput("hitCount1", 32'(hit_count), 32'd1);
`endif

      // Hit store dirties line 1, so a conflicting read must write it back first.
      applyStimulus("hitWrite06", 1'b0, 1'b1, 8'h06, 8'h5A, 8'h00, 0);
      memExp.push_back('{1'b1, 6'h01, 32'hDD5ABBAA});
      memExp.push_back('{1'b0, 6'h09, 32'h0});
      applyStimulus("dirtyRead24", 1'b1, 1'b0, 8'h24, 8'h00, 8'h44, DIRTY_MISS);

      // Both strobes high is no request even though 8'h05 would now miss.
      @(negedge clock);
      read    = 1'b1;
      write   = 1'b1;
      address = 8'h05;
      #1;
      checkOutput("both_busywait", 32'(busywait), 32'd0);
      repeat (3) @(negedge clock);
      #1;
      checkOutput("both_busywaitLater", 32'(busywait), 32'd0);
      checkOutput("both_memReq", 32'({mem_read, mem_write}), 32'd0);
      applyStimulus("afterBoth24", 1'b1, 1'b0, 8'h24, 8'h00, 8'h44, 0);

      // Store miss allocates then merges; evicting it later writes the merged block back.
      memExp.push_back('{1'b0, 6'h0A, 32'h0});
      applyStimulus("missWrite2B", 1'b0, 1'b1, 8'h2B, 8'h77, 8'h00, CLEAN_MISS);
      applyStimulus("hitRead2B", 1'b1, 1'b0, 8'h2B, 8'h00, 8'h77, 0);
      memExp.push_back('{1'b1, 6'h0A, 32'h770A0A0A});
      memExp.push_back('{1'b0, 6'h02, 32'h0});
      applyStimulus("dirtyRead0B", 1'b1, 1'b0, 8'h0B, 8'h00, 8'h02, DIRTY_MISS);

      // Reset in the middle of an allocate drops the memory request at once.
      @(negedge clock);
      read    = 1'b1;
      write   = 1'b0;
      address = 8'h05;
      repeat (2) @(negedge clock);
      #1;
      checkOutput("alloc_memRead", 32'(mem_read), 32'd1);
      checkOutput("alloc_memAddr", 32'(mem_address), 32'h01);
      reset = 1'b0;
      #1;
      checkOutput("abort_memRead", 32'(mem_read), 32'd0);
      checkOutput("abort_busywait", 32'(busywait), 32'd0);
      checkOutput("abort_memAddr", 32'(mem_address), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      read  = 1'b0;
      memExp.push_back('{1'b0, 6'h01, 32'h0});
      applyStimulus("rereadAfterRst05", 1'b1, 1'b0, 8'h05, 8'h00, 8'hBB, CLEAN_MISS);

      // Back-to-back hits on different lines with no bubble between them.
      memExp.push_back('{1'b0, 6'h03, 32'h0});
      applyStimulus("missWrite0C", 1'b0, 1'b1, 8'h0C, 8'h3C, 8'h00, CLEAN_MISS);
      applyStimulus("b2bRead05", 1'b1, 1'b0, 8'h05, 8'h00, 8'hBB, 0);
      applyStimulus("b2bRead0C", 1'b1, 1'b0, 8'h0C, 8'h00, 8'h3C, 0);
      applyStimulus("b2bRead0D", 1'b1, 1'b0, 8'h0D, 8'h00, 8'h03, 0);

`ifdef DCACHE_STATS_EN
      // Long run of hits drives the hit counter into saturation.
      @(negedge clock);
      read    = 1'b1;
      write   = 1'b0;
      address = 8'h05;
      repeat (70000) @(negedge clock);
      #1;
      checkOutput("hitCountSat", 32'(hit_count), 32'h0000FFFF);
      checkOutput("missCountEnd", 32'(miss_count), 32'd2);
`endif

      @(negedge clock);
      read  = 1'b0;
      write = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      checkOutput("memQueueEmpty", 32'(memExp.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
